// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register with valid/ready handshake,
// optional two-entry skid buffer and synchronous flush.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned SKID   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_count
);

    // Encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]        state_q,     state_nxt;
    logic [DATA_W-1:0] main_data_q, main_data_nxt;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_nxt;
    logic [DATA_W-1:0] skid_data_q, skid_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_nxt;
    logic              accept;
    logic              transfer;

    assign o_valid = (state_q != ST_EMPTY);
    assign o_count = state_q;
    assign o_data  = main_data_q;
    assign o_ctrl  = main_ctrl_q;

    // With the skid buffer, ready comes straight from state flops; without it
    // a single gate from downstream ready is allowed.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign o_ready = (state_q != ST_SKID);
        end else begin : g_reg_ready
            assign o_ready = (state_q == ST_EMPTY) | i_ready;
        end
    endgenerate

    assign accept   = i_valid & o_ready;
    assign transfer = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_nxt;
            main_data_q <= main_data_nxt;
            main_ctrl_q <= main_ctrl_nxt;
            skid_data_q <= skid_data_nxt;
            skid_ctrl_q <= skid_ctrl_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        main_data_nxt = main_data_q;
        main_ctrl_nxt = main_ctrl_q;
        skid_data_nxt = skid_data_q;
        skid_ctrl_nxt = skid_ctrl_q;

        if (i_flush) begin
            state_nxt     = ST_EMPTY;
            main_data_nxt = '0;
            main_ctrl_nxt = '0;
            skid_data_nxt = '0;
            skid_ctrl_nxt = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt     = ST_FULL;
                        main_data_nxt = i_data;
                        main_ctrl_nxt = i_ctrl;
                    end
                end
                ST_FULL: begin
                    // Without a skid buffer, accept in FULL implies transfer.
                    if (accept && transfer) begin
                        main_data_nxt = i_data;
                        main_ctrl_nxt = i_ctrl;
                    end else if (accept) begin
                        state_nxt     = ST_SKID;
                        skid_data_nxt = i_data;
                        skid_ctrl_nxt = i_ctrl;
                    end else if (transfer) begin
                        state_nxt     = ST_EMPTY;
                        main_ctrl_nxt = '0;
                    end
                end
                ST_SKID: begin
                    if (transfer) begin
                        state_nxt     = ST_FULL;
                        main_data_nxt = skid_data_q;
                        main_ctrl_nxt = skid_ctrl_q;
                    end
                end
                default: begin
                    state_nxt     = ST_EMPTY;
                    main_ctrl_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid-buffer instance and single-register instance share stimulus.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          rdy1, val1, rdy0, val0;
    logic [DW-1:0] dat1, dat0;
    logic [CW-1:0] ctl1, ctl0;
    logic [1:0]    cnt1, cnt0;

    int n_cmp;
    int n_err;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(in_valid),
        .o_ready(rdy1), .i_data(in_data), .i_ctrl(in_ctrl), .o_valid(val1),
        .i_ready(out_ready), .o_data(dat1), .o_ctrl(ctl1), .o_count(cnt1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(in_valid),
        .o_ready(rdy0), .i_data(in_data), .i_ctrl(in_ctrl), .o_valid(val0),
        .i_ready(out_ready), .o_data(dat0), .o_ctrl(ctl0), .o_count(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(val1), 32'd0);
        check("rst_count", 32'(cnt1), 32'd0);
        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_data",  32'(dat1), 32'd0);
        check("rst_ctrl",  32'(ctl1), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming 1..8 with downstream always ready
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push(DW'(k), CW'(k));
            tick();
            check("stream_data",  32'(dat1), 32'(k));
            check("stream_count", 32'(cnt1), 32'd1);
            check("stream_ready", 32'(rdy1), 32'd1);
            check("stream_valid", 32'(val1), 32'd1);
        end

        // Drain of a single entry with ctrl 101
        push(16'h0055, 3'b101);
        tick();
        check("drain_ctrl_in", 32'(ctl1), 32'h5);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(val1), 32'd0);
        check("drain_ctrl",  32'(ctl1), 32'd0);
        check("drain_data",  32'(dat1), 32'h55);
        check("drain_count", 32'(cnt1), 32'd0);

        // Backpressure: A, B fill the stage, C waits upstream
        out_ready = 1'b0;
        push(16'h00A1, 3'd1);
        tick();
        check("bp_a_data",  32'(dat1), 32'hA1);
        check("bp_a_ready", 32'(rdy1), 32'd1);
        push(16'h00B2, 3'd2);
        tick();
        check("bp_b_count", 32'(cnt1), 32'd2);
        check("bp_b_ready", 32'(rdy1), 32'd0);
        check("bp_b_data",  32'(dat1), 32'hA1);
        push(16'h00C3, 3'd3);
        tick();
        check("bp_hold_count", 32'(cnt1), 32'd2);
        check("bp_hold_data",  32'(dat1), 32'hA1);
        out_ready = 1'b1;
        tick();
        check("bp_out_b",   32'(dat1), 32'hB2);
        check("bp_out_b_c", 32'(ctl1), 32'd2);
        check("bp_cnt_b",   32'(cnt1), 32'd1);
        check("bp_rdy_b",   32'(rdy1), 32'd1);
        tick();
        check("bp_out_c",   32'(dat1), 32'hC3);
        check("bp_cnt_c",   32'(cnt1), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_empty",   32'(cnt1), 32'd0);

        // Flush while holding two entries, with a new input presented
        out_ready = 1'b0;
        push(16'h00D4, 3'd4);
        tick();
        push(16'h00E5, 3'd5);
        tick();
        check("fl_pre_count", 32'(cnt1), 32'd2);
        flush = 1'b1;
        push(16'h00F6, 3'b111);
        tick();
        check("fl_valid", 32'(val1), 32'd0);
        check("fl_ctrl",  32'(ctl1), 32'd0);
        check("fl_count", 32'(cnt1), 32'd0);
        check("fl_ready", 32'(rdy1), 32'd1);
        check("fl_data",  32'(dat1), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_after_valid", 32'(val1), 32'd0);
        check("fl_after_count", 32'(cnt1), 32'd0);

        // Asynchronous reset mid-stream with two entries held
        out_ready = 1'b0;
        push(16'h0107, 3'd6);
        tick();
        push(16'h0208, 3'd7);
        tick();
        check("ar_pre_count", 32'(cnt1), 32'd2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(val1), 32'd0);
        check("ar_ctrl",  32'(ctl1), 32'd0);
        check("ar_data",  32'(dat1), 32'd0);
        check("ar_count", 32'(cnt1), 32'd0);
        check("ar_ready", 32'(rdy1), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-register mode
        out_ready = 1'b0;
        push(16'h0011, 3'd1);
        tick();
        check("s0_data1", 32'(dat0), 32'h11);
        check("s0_cnt1",  32'(cnt0), 32'd1);
        push(16'h0022, 3'd2);
        #1;
        check("s0_ready_lo", 32'(rdy0), 32'd0);
        tick();
        check("s0_hold", 32'(dat0), 32'h11);
        out_ready = 1'b1;
        #1;
        check("s0_ready_hi", 32'(rdy0), 32'd1);
        tick();
        check("s0_data2",  32'(dat0), 32'h22);
        check("s0_ctrl2",  32'(ctl0), 32'd2);
        check("s0_cnt2",   32'(cnt0), 32'd1);
        check("s0_valid2", 32'(val0), 32'd1);
        in_valid = 1'b0;
        tick();
        check("s0_drain_valid", 32'(val0), 32'd0);
        check("s0_drain_ctrl",  32'(ctl0), 32'd0);
        check("s0_drain_data",  32'(dat0), 32'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, optional 2-entry skid buffer, and synchronous flush. Generalises the fixed-field inter-stage registers (IF/ID … MEM/WB) into one reusable block. Payload is split into a data field and a control field; the control field is cleared whenever the stage holds a bubble. Sits between any two pipeline stages of the forwarding/hazard pipeline models and absorbs one cycle of downstream stall without combinational ready paths.

## Interface
- DATA_W, 128: width of data payload (e.g. pc, inst, alu, mem concatenated)
- CTRL_W, 3: width of control payload (e.g. wb_sel, regwen); zeroed on bubble
- SKID, 1: 1 = 2-entry skid buffer with registered o_ready; 0 = single register with combinational o_ready
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_flush  in  1  synchronous flush; highest priority after reset
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept this cycle
- i_data  in  DATA_W  upstream data payload
- i_ctrl  in  CTRL_W  upstream control payload
- o_valid  out  1  downstream entry valid
- i_ready  in  1  downstream accepts this cycle
- o_data  out  DATA_W  registered data payload
- o_ctrl  out  CTRL_W  registered control payload
- o_count  out  2  entries held (0, 1, 2)

## Operation
- accept = i_valid & o_ready; transfer = o_valid & i_ready.
- SKID=1 states: EMPTY (count 0), FULL (main only, count 1), SKID (main+skid, count 2). o_ready = (state != SKID), decoded from state flops only.
  - EMPTY: accept → FULL, main ← input.
  - FULL: accept&transfer → FULL, main ← input; accept&!transfer → SKID, skid ← input; transfer&!accept → EMPTY; else hold.
  - SKID: transfer → FULL, main ← skid; else hold. No accept possible.
- SKID=0: states EMPTY/FULL only; o_ready = !o_valid | i_ready; accept overwrites main in same cycle as transfer.
- o_valid = (state != EMPTY). o_data/o_ctrl always driven from main register.
- Entering EMPTY by drain: o_ctrl ← 0; o_data holds last value.
- i_flush=1: state → EMPTY, main and skid data and ctrl ← 0, o_count → 0; concurrent accept and transfer are discarded (upstream entry dropped, no transfer counted).
- i_valid while !o_ready: ignored; upstream must hold.
- Ordering strictly FIFO; no entry duplicated or lost except by flush.

## Timing
- Reset (i_reset=0, async): o_valid=0, o_data=0, o_ctrl=0, o_count=0, o_ready=1, skid regs 0; holds while asserted, effective immediately mid-operation.
- Latency: input accepted at edge N appears on o_data/o_ctrl after edge N, o_valid=1 in cycle N+1.
- Throughput: 1 entry/cycle with i_ready=1 in both modes.
- SKID=1: o_ready deasserts the cycle after the second entry is captured; reasserts the cycle after the first transfer from SKID.
- SKID=1: no combinational path i_ready → o_ready. SKID=0: one-gate path permitted.
- Flush at edge N: o_valid=0, o_ctrl=0 in cycle N+1; o_ready=1 in cycle N+1.

## Test plan
- Reset: drive i_reset=0 mid-stream with count=2 → o_valid=0, o_ctrl=0, o_data=0, o_count=0, o_ready=1 immediately, no clock needed.
- Streaming: SKID=1, i_ready=1, i_data=1..8 on consecutive cycles → o_data=1..8 one cycle later, o_count stays 1, o_ready stays 1.
- Backpressure: i_ready=0, push A, B → o_count=2, o_ready=0, o_data=A; C held upstream; raise i_ready → outputs A, B, C in order, no loss.
- Flush in SKID state with i_valid=1, i_ctrl=3'b111 → next cycle o_valid=0, o_ctrl=0, o_count=0; flushed input never appears.
- Drain: single entry with ctrl=3'b101 transferred, no new input → o_valid=0, o_ctrl=0, o_data unchanged.
- SKID=0: i_ready=0 with entry held → o_ready=0 same cycle; i_ready=1 with i_valid=1 → transfer and accept same edge, o_count stays 1.
